// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter onto one memory port with a response watchdog.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed LSU priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MASK_W  = DATA_W / 8;
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND_REQ, WAIT_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_lsu;
    logic [TIMER_W-1:0]  r_timer;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic w_prefer_lsu;
    logic w_grant_lsu;
    logic w_grant_ifu;
    logic w_handshake;
    logic w_timed_out;
    logic w_owner_resp_ready;
    logic w_resp_valid;
    logic [DATA_W-1:0] w_resp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_lsu;

    always_ff @(posedge clk) begin
        if (rst)
            r_last_lsu <= 1'b0;
        else if (w_handshake)
            r_last_lsu <= w_grant_lsu;
    end

    assign w_prefer_lsu = ~r_last_lsu;
`else
    assign w_prefer_lsu = 1'b1;
`endif

    // Contention is resolved by w_prefer_lsu; a lone requester always wins.
    assign w_grant_lsu = lsu_req_valid & (~ifu_req_valid | w_prefer_lsu);
    assign w_grant_ifu = ifu_req_valid & ~w_grant_lsu;
    assign w_handshake = (r_state == IDLE) & (lsu_req_valid | ifu_req_valid);

    assign w_timed_out        = (r_state == WAIT_RESP) && (r_timer == TIMER_W'(TIMEOUT));
    assign w_owner_resp_ready = r_owner_lsu ? lsu_resp_ready : ifu_resp_ready;
    assign w_resp_valid       = (r_state == WAIT_RESP) & (w_timed_out | mem_resp_valid);
    assign w_resp_data        = w_timed_out ? '0 : mem_rdata;

    assign mem_req_valid = (r_state == SEND_REQ);
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_err   = 1'b0;
        mem_resp_ready = 1'b0;
        case (r_state)
            IDLE: begin
                ifu_req_ready = w_grant_ifu;
                lsu_req_ready = w_grant_lsu;
                if (w_handshake)
                    w_state_nxt = SEND_REQ;
            end
            SEND_REQ: begin
                if (mem_req_ready)
                    w_state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                // After a timeout the slave is cut off; the owner sees an error beat instead.
                mem_resp_ready = ~w_timed_out & w_owner_resp_ready;
                if (r_owner_lsu) begin
                    lsu_resp_valid = w_resp_valid;
                    lsu_rdata      = w_resp_data;
                    lsu_resp_err   = w_timed_out;
                end else begin
                    ifu_resp_valid = w_resp_valid;
                    ifu_rdata      = w_resp_data;
                    ifu_resp_err   = w_timed_out;
                end
                if (w_resp_valid & w_owner_resp_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_lsu <= 1'b0;
            r_timer     <= '0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_owner_lsu <= w_grant_lsu;
                        r_addr      <= w_grant_lsu ? lsu_addr : ifu_addr;
                        r_wen       <= w_grant_lsu & lsu_wen;
                        r_wdata     <= w_grant_lsu ? lsu_wdata : '0;
                        r_wmask     <= w_grant_lsu ? lsu_wmask : '0;
                    end
                end
                SEND_REQ: begin
                    if (mem_req_ready)
                        r_timer <= '0;
                end
                WAIT_RESP: begin
                    if (!mem_resp_valid && !w_timed_out)
                        r_timer <= r_timer + TIMER_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_order [4];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        tick(); tick();
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_payload", {mem_wen, mem_wmask, mem_addr[26:0]}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_resp", {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err, mem_resp_ready}, 0);
        check("rst_rdata", ifu_rdata | lsu_rdata, 0);
        rst = 1'b0;

        // Test 1: IFU only, response two cycles into WAIT_RESP
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; #1;
        check("t1_ifu_ready", {ifu_req_ready, lsu_req_ready, mem_req_valid}, 3'b100);
        tick(); ifu_req_valid = 0; #1;
        check("t1_mem_req_valid", mem_req_valid, 1);
        check("t1_mem_addr", mem_addr, 32'h8000_0000);
        check("t1_mem_wen", mem_wen, 0);
        mem_req_ready = 1; tick(); mem_req_ready = 0; #1;
        check("t1_wait_no_resp", ifu_resp_valid, 0);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h0000_0413; ifu_resp_ready = 1; #1;
        check("t1_ifu_resp", {ifu_resp_valid, ifu_resp_err, lsu_resp_valid, mem_resp_ready}, 4'b1001);
        check("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        tick(); mem_resp_valid = 0; ifu_resp_ready = 0; #1;
        check("t1_back_idle", {ifu_resp_valid, mem_req_valid}, 0);

        // Dropped request before handshake gets no grant
        lsu_req_valid = 1; #1;
        lsu_req_valid = 0; tick();
        check("drop_no_grant", mem_req_valid, 0);

        // Tests 2 and 3: simultaneous requests, LSU store stalled 5 cycles by mem_req_ready
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; #1;
        check("t2_grant_lsu", {lsu_req_ready, ifu_req_ready}, 2'b10);
        tick(); lsu_req_valid = 0; #1;
        check("t2_mem_wen", mem_wen, 1);
        check("t2_mem_addr", mem_addr, 32'h8000_1000);
        check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t2_mem_wmask", mem_wmask, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", {mem_req_valid, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready}, 8'b1_1_1111_00);
            check("t3_hold_addr", mem_addr, 32'h8000_1000);
            check("t3_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        mem_resp_valid = 1; mem_rdata = 32'h1111_2222; #1;
        check("t2_lsu_resp_wait", {lsu_resp_valid, mem_resp_ready, ifu_resp_valid, ifu_req_ready}, 4'b1000);
        tick(); lsu_resp_ready = 1; #1;
        check("t2_lsu_resp_hs", {lsu_resp_valid, mem_resp_ready, lsu_resp_err}, 3'b110);
        tick(); mem_resp_valid = 0; lsu_resp_ready = 0; lsu_wen = 0; #1;
        check("t2_ifu_after", {ifu_req_ready, lsu_req_ready}, 2'b10);
        tick(); ifu_req_valid = 0; #1;
        check("t2_ifu_addr", mem_addr, 32'h8000_0004);
        check("t2_ifu_forced", {mem_wen, mem_wmask, mem_wdata[22:0]}, 0);
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        mem_resp_valid = 1; ifu_resp_ready = 1; tick();
        mem_resp_valid = 0; ifu_resp_ready = 0;

        // Test 4: watchdog on a silent slave
        ifu_req_valid = 1; ifu_addr = 32'h8000_0008; tick(); ifu_req_valid = 0;
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        for (int i = 0; i < 254; i++) tick();
        check("t4_before_timeout", ifu_resp_valid, 0);
        tick();
        check("t4_timeout", {ifu_resp_valid, ifu_resp_err, mem_resp_ready, lsu_resp_valid}, 4'b1100);
        check("t4_rdata_zero", ifu_rdata, 0);
        mem_resp_valid = 1; mem_rdata = 32'h0000_1234; #1;
        check("t4_late_blocked", {ifu_rdata[15:0], mem_resp_ready}, 0);
        tick();
        check("t4_held", {ifu_resp_valid, ifu_resp_err}, 2'b11);
        ifu_resp_ready = 1; tick(); ifu_resp_ready = 0; mem_resp_valid = 0; #1;
        check("t4_idle", {ifu_resp_valid, ifu_resp_err, mem_req_valid}, 0);

        // Test 5: reset during WAIT_RESP
        ifu_req_valid = 1; ifu_addr = 32'h8000_000C; tick(); ifu_req_valid = 0;
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA; #1;
        check("t5_pre_rst", ifu_resp_valid, 1);
        rst = 1; tick(); rst = 0; #1;
        check("t5_post_rst", {ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready}, 0);
        check("t5_addr_clr", mem_addr, 0);
        mem_resp_valid = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010; #1;
        check("t5_regrant", ifu_req_ready, 1);
        tick(); ifu_req_valid = 0; #1;
        check("t5_mem_addr", {mem_req_valid, mem_addr[30:0]}, 32'h8000_0010);
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        mem_resp_valid = 1; ifu_resp_ready = 1; tick();
        mem_resp_valid = 0; ifu_resp_ready = 0;

        // Test 6: both held valid for four transactions ({lsu,ifu} grant)
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_order = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        ifu_req_valid = 1; ifu_addr = 32'h8000_0020;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_2000;
        lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'h3;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t6_grant", {lsu_req_ready, ifu_req_ready}, exp_order[i]);
            tick();
            check("t6_mem_wen", mem_wen, exp_order[i][1]);
            mem_req_ready = 1; tick(); mem_req_ready = 0;
            mem_resp_valid = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
            tick();
            mem_resp_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one physical memory port (DPI-backed SRAM) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between IFU/LSU and the memory slave.
- Grants one transaction at a time, holds the grant until the response handshake completes, then routes the response back to the owner.
- Includes a response watchdog so a hung slave cannot deadlock the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT, 255, max cycles in WAIT_RESP before a forced error response (counter width = clog2(TIMEOUT+1)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU request valid
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU can take response
- ifu_rdata  out  DATA_W  fetched instruction
- ifu_resp_err  out  1  IFU response is a timeout error
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_resp_valid  out  1  LSU response valid
- lsu_resp_ready  in  1  LSU can take response
- lsu_rdata  out  DATA_W  load data
- lsu_resp_err  out  1  LSU response is a timeout error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DATA_W  registered write data
- mem_wmask  out  DATA_W/8  registered strobes
- mem_resp_valid  in  1  memory response valid
- mem_resp_ready  out  1  arbiter can take response
- mem_rdata  in  DATA_W  memory read data

Behaviour:

Reset:
- state = IDLE, owner = IFU, last_grant = IFU, timer = 0.
- All valid/ready outputs 0; mem_addr, mem_wdata, mem_wmask and mem_wen = 0.
- rdata outputs = 0; err outputs = 0.

States: IDLE, SEND_REQ, WAIT_RESP.

IDLE:
- Grant is combinational from the current valids.
- LSU wins over IFU when both are valid (fixed priority).
- Only the granted side sees req_ready = 1; the other side's req_ready = 0.
- On the grant handshake:
  - latch owner and the payload (IFU forces wen = 0, wmask = 0, wdata = 0);
  - go to SEND_REQ.
- No valid request: stay in IDLE.

SEND_REQ:
- mem_req_valid = 1 with the latched payload; the payload is stable until accepted.
- On mem_req_ready: clear timer, go to WAIT_RESP.

WAIT_RESP:
- mem_resp_ready mirrors the owner's resp_ready.
- Owner's resp_valid mirrors mem_resp_valid; owner's rdata = mem_rdata.
- Non-owner resp_valid = 0.
- On mem_resp_valid & mem_resp_ready: go to IDLE.
- Timer increments every cycle without mem_resp_valid.
- When timer reaches TIMEOUT:
  - owner's resp_valid = 1, rdata = 0, resp_err = 1, mem_resp_ready = 0;
  - held until the owner handshakes, then go to IDLE.
  - A late mem response is not forwarded.

Latency:
- Grant handshake at cycle N; mem_req_valid rises at N+1 at the earliest.
- Responses pass through with zero added latency.
- Minimum total is 3 cycles per transaction.

Boundaries:
- req_ready = 0 in SEND_REQ and WAIT_RESP; new requests wait.
- A requester dropping valid in IDLE before the handshake gets no grant.
- Store responses are still routed; the LSU must handshake them (rdata is don't-care).
- Reset mid-transaction returns to IDLE at the next edge. Any in-flight memory transaction is abandoned; the slave shares rst.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both request in IDLE, grant goes to the side not equal to last_grant.
  - last_grant updates on every grant handshake.
  - A single requester is always granted immediately.
- Undefined: fixed LSU priority; last_grant is unused and may be optimized away.

Test Plan:
1. IFU only, addr 0x80000000, memory returns 0x00000413 after 2 cycles. Required: ifu_req_ready at cycle 0; mem_req_valid from cycle 1 with mem_addr 0x80000000, mem_wen 0; ifu_resp_valid with rdata 0x00000413; lsu_resp_valid stays 0.
2. IFU and LSU valid in the same cycle, LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF. Required: LSU granted first with mem_wen 1; IFU granted only after the LSU response handshake.
3. mem_req_ready held low for 5 cycles. Required: mem_req_valid and the payload stay stable for all 5 cycles; no second grant occurs.
4. IFU granted, then mem_resp_valid never asserts. Required: after TIMEOUT (255) cycles in WAIT_RESP, ifu_resp_valid 1, ifu_resp_err 1, ifu_rdata 0; return to IDLE after the handshake.
5. rst asserted in WAIT_RESP. Required: next cycle is IDLE with all valids 0; a new IFU request is granted normally afterwards.
6. With MEM_ARB_ROUND_ROBIN_EN, both requesters held valid for 4 transactions. Required: grant order LSU, IFU, LSU, IFU (last_grant reset = IFU).
